sd_spi_arbiter: RTL and testbench

Shares the single SD-card SPI bus (CS, MOSI) between three masters: the card initializer (req 0), the sector reader (req 1) and the sector writer (req 2).
- Replaces the ad-hoc MOSI mux in the SD top level.
- Grants the bus to one master at a time and holds the grant until that master releases it.
- Inserts a CS-high idle gap between owners.
- Guards against a hung master with a grant timeout.
- Runs on the divided SPI bit clock, the same clock that drives SCLK.

---
 rtl/sd_bus_pkg.sv | 26 ++
 rtl/sd_rr_picker.sv | 31 +++
 rtl/sd_spi_arbiter.sv | 148 ++++++++++++++
 tb/tb_sd_spi_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_bus_pkg.sv
// Shared encodings for the SD-card SPI bus arbiter and its winner picker.
package sd_bus_pkg;

   localparam logic [1:0] sIDLE  = 2'd0;
   localparam logic [1:0] sGRANT = 2'd1;
   localparam logic [1:0] sGAP   = 2'd2;

   localparam logic [1:0] REQ_INIT  = 2'd0;
   localparam logic [1:0] REQ_READ  = 2'd1;
   localparam logic [1:0] REQ_WRITE = 2'd2;

   localparam logic [1:0] OWNER_NONE = 2'd3;

   function automatic logic [2:0] idx_to_onehot(input logic [1:0] idx);
      logic [2:0] oh;
      oh = 3'b000;
      case (idx)
         REQ_INIT:  oh = 3'b001;
         REQ_READ:  oh = 3'b010;
         REQ_WRITE: oh = 3'b100;
         default:   oh = 3'b000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/sd_rr_picker.sv
// Winner select: initializer has absolute priority, reader/writer alternate on a tie.
// Latency: purely combinational.
// Backpressure: none; locked-out requesters are simply ineligible.
module sd_rr_picker
   import sd_bus_pkg::*;
(
   input  logic [2:0] req,
   input  logic [2:0] lockout,
   input  logic [1:0] rr_last,
   output logic       win_vld,
   output logic [1:0] win_idx
);

   logic [2:0] elig;

   assign elig = req & ~lockout;

   always_comb begin
      win_vld = |elig;
      win_idx = OWNER_NONE;
      if (elig[0])
         win_idx = REQ_INIT;
      else if (elig[1] && elig[2])
         win_idx = (rr_last == REQ_READ) ? REQ_WRITE : REQ_READ;
      else if (elig[1])
         win_idx = REQ_READ;
      else if (elig[2])
         win_idx = REQ_WRITE;
   end

endmodule

// File: rtl/sd_spi_arbiter.sv
// Shares the SD-card SPI CS/MOSI between initializer, reader and writer, one owner at a time.
// Latency: grant registered one edge after a request is seen in IDLE; CS/MOSI follow the owner combinationally.
// Backpressure: non-owners wait; owner keeps the bus until it drops req or the hold timer expires.
module sd_spi_arbiter
   import sd_bus_pkg::*;
#(
   parameter int GAP_CYCLES = 8,
   parameter int TIMEOUT_W  = 20
)
(
   input  logic       clock,
   input  logic       reset,
   input  logic [2:0] req,
   input  logic [2:0] req_mosi,
   input  logic [2:0] req_cs,
   output logic [2:0] grant,
   output logic [1:0] owner,
   output logic       CS,
   output logic       MOSI,
   output logic       busy,
   output logic       timeout_err,
   output logic [1:0] err_owner
);

   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   // The edge that would carry the hold counter to all-ones is the timeout edge.
   localparam logic [TIMEOUT_W-1:0] HOLD_LAST = {TIMEOUT_W{1'b1}} - 1'b1;

   logic [1:0]           state, state_nx;
   logic [TIMEOUT_W-1:0] hold_cnt, hold_cnt_nx;
   logic [GAP_W-1:0]     gap_cnt, gap_cnt_nx;
   logic [2:0]           grant_nx;
   logic [1:0]           owner_nx;
   logic [1:0]           rr_last, rr_last_nx;
   logic [2:0]           lockout, lockout_nx, lock_set;
   logic                 terr_nx;
   logic [1:0]           err_owner_nx;

   logic                 win_vld;
   logic [1:0]           win_idx;
   logic                 own_req;
   logic                 own_cs;
   logic                 own_mosi;

   sd_rr_picker u_picker (
      .req     (req),
      .lockout (lockout),
      .rr_last (rr_last),
      .win_vld (win_vld),
      .win_idx (win_idx)
   );

   // grant is one-hot while owned, so masking selects the owner's lines without an index.
   assign own_req  = |(req & grant);
   assign own_cs   = |(req_cs & grant);
   assign own_mosi = |(req_mosi & grant);

   assign CS   = (state == sGRANT) ? own_cs   : 1'b1;
   assign MOSI = (state == sGRANT) ? own_mosi : 1'b1;
   assign busy = (state != sIDLE);

   always_comb begin
      state_nx     = state;
      hold_cnt_nx  = hold_cnt;
      gap_cnt_nx   = gap_cnt;
      grant_nx     = grant;
      owner_nx     = owner;
      rr_last_nx   = rr_last;
      terr_nx      = timeout_err;
      err_owner_nx = err_owner;
      lock_set     = 3'b000;

      case (state)
         sIDLE: begin
            if (win_vld) begin
               state_nx    = sGRANT;
               grant_nx    = idx_to_onehot(win_idx);
               owner_nx    = win_idx;
               hold_cnt_nx = '0;
               if (win_idx != REQ_INIT)
                  rr_last_nx = win_idx;
            end
         end

         sGRANT: begin
            if (!own_req || (hold_cnt == HOLD_LAST)) begin
               // A release landing on the timeout edge counts as a clean release.
               if (own_req) begin
                  terr_nx      = 1'b1;
                  err_owner_nx = owner;
                  lock_set     = grant;
               end
               grant_nx = 3'b000;
               owner_nx = OWNER_NONE;
               if (GAP_CYCLES == 0) begin
                  state_nx = sIDLE;
               end else begin
                  state_nx   = sGAP;
                  gap_cnt_nx = GAP_LOAD;
               end
            end
            if (hold_cnt != {TIMEOUT_W{1'b1}})
               hold_cnt_nx = hold_cnt + 1'b1;
         end

         sGAP: begin
            if (gap_cnt == '0)
               state_nx = sIDLE;
            else
               gap_cnt_nx = gap_cnt - 1'b1;
         end

         default: begin
            state_nx = sIDLE;
            grant_nx = 3'b000;
            owner_nx = OWNER_NONE;
         end
      endcase

      lockout_nx = (lockout | lock_set) & req;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= sIDLE;
         hold_cnt    <= '0;
         gap_cnt     <= '0;
         grant       <= 3'b000;
         owner       <= OWNER_NONE;
         rr_last     <= REQ_WRITE;
         lockout     <= 3'b000;
         timeout_err <= 1'b0;
         err_owner   <= 2'd0;
      end else begin
         state       <= state_nx;
         hold_cnt    <= hold_cnt_nx;
         gap_cnt     <= gap_cnt_nx;
         grant       <= grant_nx;
         owner       <= owner_nx;
         rr_last     <= rr_last_nx;
         lockout     <= lockout_nx;
         timeout_err <= terr_nx;
         err_owner   <= err_owner_nx;
      end
   end

endmodule

// File: tb/tb_sd_spi_arbiter.sv
// Directed bench: arbiter with an 8-cycle gap and 4-bit hold timer, plus a zero-gap build.
module tb_sd_spi_arbiter;

   logic       clock;
   logic       reset;
   logic [2:0] req, req_mosi, req_cs;
   logic [2:0] grant;
   logic [1:0] owner;
   logic       CS, MOSI, busy, timeout_err;
   logic [1:0] err_owner;

   logic [2:0] z_req, z_req_mosi, z_req_cs;
   logic [2:0] z_grant;
   logic [1:0] z_owner;
   logic       z_CS, z_MOSI, z_busy, z_timeout_err;
   logic [1:0] z_err_owner;

   int n_assert;
   int n_fail;

   sd_spi_arbiter #(.GAP_CYCLES(8), .TIMEOUT_W(4)) u_dut (
      .clock       (clock),
      .reset       (reset),
      .req         (req),
      .req_mosi    (req_mosi),
      .req_cs      (req_cs),
      .grant       (grant),
      .owner       (owner),
      .CS          (CS),
      .MOSI        (MOSI),
      .busy        (busy),
      .timeout_err (timeout_err),
      .err_owner   (err_owner)
   );

   sd_spi_arbiter #(.GAP_CYCLES(0), .TIMEOUT_W(4)) u_dut_nogap (
      .clock       (clock),
      .reset       (reset),
      .req         (z_req),
      .req_mosi    (z_req_mosi),
      .req_cs      (z_req_cs),
      .grant       (z_grant),
      .owner       (z_owner),
      .CS          (z_CS),
      .MOSI        (z_MOSI),
      .busy        (z_busy),
      .timeout_err (z_timeout_err),
      .err_owner   (z_err_owner)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      n_assert   = 0;
      n_fail     = 0;
      reset      = 1'b0;
      req        = 3'b000;
      req_cs     = 3'b111;
      req_mosi   = 3'b111;
      z_req      = 3'b000;
      z_req_cs   = 3'b111;
      z_req_mosi = 3'b111;

      // Reset state
      tick();
      tick();
      chk("rst_grant", grant, 3'b000);
      chk("rst_owner", {1'b0, owner}, 3'd3);
      chk("rst_cs", {2'b0, CS}, 3'd1);
      chk("rst_mosi", {2'b0, MOSI}, 3'd1);
      chk("rst_busy", {2'b0, busy}, 3'd0);
      chk("rst_terr", {2'b0, timeout_err}, 3'd0);
      chk("rst_eown", {1'b0, err_owner}, 3'd0);

      // 1: initializer alone, CS/MOSI pass-through, 8-cycle gap
      reset = 1'b1;
      tick();
      req = 3'b001;
      tick();
      chk("t1_grant", grant, 3'b001);
      chk("t1_owner", {1'b0, owner}, 3'd0);
      chk("t1_busy", {2'b0, busy}, 3'd1);
      chk("t1_cs_hi", {2'b0, CS}, 3'd1);
      req_cs   = 3'b110;
      req_mosi = 3'b110;
      #1;
      chk("t1_cs_follow", {2'b0, CS}, 3'd0);
      chk("t1_mosi_lo", {2'b0, MOSI}, 3'd0);
      req_mosi = 3'b111;
      #1;
      chk("t1_mosi_hi", {2'b0, MOSI}, 3'd1);
      req_mosi = 3'b100;
      #1;
      chk("t1_mosi_nonowner", {2'b0, MOSI}, 3'd0);
      req_mosi = 3'b110;
      req      = 3'b000;
      tick();
      chk("t1_rel_grant", grant, 3'b000);
      chk("t1_rel_owner", {1'b0, owner}, 3'd3);
      chk("t1_gap_cs", {2'b0, CS}, 3'd1);
      chk("t1_gap_mosi", {2'b0, MOSI}, 3'd1);
      chk("t1_gap_busy0", {2'b0, busy}, 3'd1);
      for (int i = 1; i < 8; i++) begin
         tick();
         chk("t1_gap_busy", {2'b0, busy}, 3'd1);
         chk("t1_gap_cs_n", {2'b0, CS}, 3'd1);
      end
      tick();
      chk("t1_idle_busy", {2'b0, busy}, 3'd0);
      req_cs   = 3'b111;
      req_mosi = 3'b111;

      // 2: reader/writer tie, rr_last=2 favours reader, then alternation
      req = 3'b110;
      tick();
      chk("t2_reader_first", grant, 3'b010);
      chk("t2_owner1", {1'b0, owner}, 3'd1);
      req_cs = 3'b101;
      #1;
      chk("t2_cs_reader", {2'b0, CS}, 3'd0);
      req    = 3'b100;
      req_cs = 3'b111;
      tick();
      chk("t2_rel", grant, 3'b000);
      repeat (8) tick();
      chk("t2_gap_end_nogrant", grant, 3'b000);
      tick();
      chk("t2_writer", grant, 3'b100);
      chk("t2_owner2", {1'b0, owner}, 3'd2);
      req = 3'b000;
      tick();
      repeat (8) tick();
      req = 3'b110;
      tick();
      chk("t2_alternate_reader", grant, 3'b010);

      // 3: no preemption; initializer beats pending reader after the gap
      req = 3'b100;
      tick();
      repeat (8) tick();
      tick();
      chk("t3_writer", grant, 3'b100);
      req = 3'b111;
      tick();
      tick();
      chk("t3_no_preempt", grant, 3'b100);
      chk("t3_owner_kept", {1'b0, owner}, 3'd2);
      req = 3'b011;
      tick();
      repeat (8) tick();
      chk("t3_gap_end", grant, 3'b000);
      tick();
      chk("t3_init_wins", grant, 3'b001);
      req = 3'b000;
      tick();
      repeat (8) tick();
      chk("t3_idle", {2'b0, busy}, 3'd0);

      // 5: release on the timeout edge is a clean release
      req = 3'b010;
      tick();
      repeat (14) tick();
      chk("t5_still_owned", grant, 3'b010);
      req = 3'b000;
      tick();
      chk("t5_rel", grant, 3'b000);
      chk("t5_no_err", {2'b0, timeout_err}, 3'd0);
      repeat (8) tick();
      chk("t5_idle", {2'b0, busy}, 3'd0);

      // 4: hung reader times out and is locked out until it drops req
      req = 3'b010;
      tick();
      chk("t4_grant", grant, 3'b010);
      repeat (14) tick();
      chk("t4_hold14", grant, 3'b010);
      chk("t4_no_err_yet", {2'b0, timeout_err}, 3'd0);
      tick();
      chk("t4_timeout_grant", grant, 3'b000);
      chk("t4_terr", {2'b0, timeout_err}, 3'd1);
      chk("t4_eown", {1'b0, err_owner}, 3'd1);
      chk("t4_gap_busy", {2'b0, busy}, 3'd1);
      repeat (8) tick();
      tick();
      tick();
      chk("t4_locked", grant, 3'b000);
      chk("t4_locked_idle", {2'b0, busy}, 3'd0);
      req = 3'b000;
      tick();
      req = 3'b010;
      tick();
      chk("t4_regrant", grant, 3'b010);
      chk("t4_terr_sticky", {2'b0, timeout_err}, 3'd1);

      // 6: async reset mid-grant, rr_last returns to writer so reader wins the tie
      req_cs = 3'b101;
      #1;
      chk("t6_cs_owned", {2'b0, CS}, 3'd0);
      #1;
      reset = 1'b0;
      #1;
      chk("t6_grant", grant, 3'b000);
      chk("t6_owner", {1'b0, owner}, 3'd3);
      chk("t6_cs", {2'b0, CS}, 3'd1);
      chk("t6_mosi", {2'b0, MOSI}, 3'd1);
      chk("t6_busy", {2'b0, busy}, 3'd0);
      chk("t6_terr", {2'b0, timeout_err}, 3'd0);
      req    = 3'b110;
      req_cs = 3'b111;
      tick();
      reset = 1'b1;
      tick();
      chk("t6_reader_wins", grant, 3'b010);
      chk("t6_owner1", {1'b0, owner}, 3'd1);

      // Zero-gap build: release goes straight to IDLE, next grant one edge later
      z_req = 3'b001;
      tick();
      chk("z_grant0", z_grant, 3'b001);
      z_req = 3'b100;
      tick();
      chk("z_rel", z_grant, 3'b000);
      chk("z_idle", {2'b0, z_busy}, 3'd0);
      chk("z_cs", {2'b0, z_CS}, 3'd1);
      tick();
      chk("z_grant2", z_grant, 3'b100);
      z_req = 3'b000;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
